// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter merging byte streams into one tagged UART TX stream
// Each data byte is emitted as a {tag, data} pair; grants end on tlast, burst limit or hold timeout.
module uart_tx_arbiter #(
  parameter int                     NUM_SRC     = 3,
  parameter logic [8*NUM_SRC-1:0]   SRC_TAGS    = 24'h05_02_03,
  parameter int                     MAX_BURST   = 16,
  parameter int                     HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*NUM_SRC-1:0]   src_tdata,
  input  logic [NUM_SRC-1:0]     src_tvalid,
  input  logic [NUM_SRC-1:0]     src_tlast,
  output logic [NUM_SRC-1:0]     src_tready,
  output logic [7:0]             m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [NUM_SRC-1:0]     grant,
  output logic                   busy
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         beat_cnt_q, beat_cnt_d;
  logic [7:0]         hold_cnt_q, hold_cnt_d;

  // Round-robin pick: first valid source after the pointer, wrapping.
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand_idx;
  int               cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand     = (int'(ptr_q) + k) % NUM_SRC;
      cand_idx = IDX_W'(cand);
      if (!pick_found && src_tvalid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  logic [7:0] g_tdata;
  logic [7:0] g_tag;
  logic       g_tvalid;
  logic       g_tlast;

  always_comb begin
    g_tdata  = '0;
    g_tag    = '0;
    g_tvalid = 1'b0;
    g_tlast  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) begin
        g_tdata  = src_tdata[8*i +: 8];
        g_tag    = SRC_TAGS[8*i +: 8];
        g_tvalid = src_tvalid[i];
        g_tlast  = src_tlast[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    hold_cnt_d = hold_cnt_q;
    m_tvalid   = 1'b0;
    m_tdata    = '0;
    src_tready = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
          beat_cnt_d        = '0;
          state_d           = ST_HDR;
        end
      end

      ST_HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = g_tag;
        if (m_tready) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        m_tvalid   = g_tvalid;
        m_tdata    = g_tdata;
        src_tready = grant_q & {NUM_SRC{m_tready}};
        if (g_tvalid && m_tready) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          // tlast and burst limit on the same byte resolve to one release
          if (g_tlast || (beat_cnt_q == 8'(MAX_BURST - 1))) begin
            ptr_d   = gidx_q;
            grant_d = '0;
            state_d = ST_IDLE;
          end else begin
            hold_cnt_d = '0;
            state_d    = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (g_tvalid) begin
          state_d = ST_HDR;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
          if (hold_cnt_q == 8'(HOLD_CYCLES - 1)) begin
            ptr_d   = gidx_q;
            grant_d = '0;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      ptr_q      <= IDX_W'(NUM_SRC - 1);
      beat_cnt_q <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int NS = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [8*NS-1:0] src_tdata;
  logic [NS-1:0]   src_tvalid;
  logic [NS-1:0]   src_tlast;
  logic [NS-1:0]   src_tready;
  logic [7:0]      m_tdata;
  logic            m_tvalid;
  logic            m_tready;
  logic [NS-1:0]   grant;
  logic            busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_SRC(3), .SRC_TAGS(24'h05_02_03), .MAX_BURST(16), .HOLD_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .src_tdata(src_tdata), .src_tvalid(src_tvalid), .src_tlast(src_tlast),
    .src_tready(src_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .grant(grant), .busy(busy)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [7:0] gap;
  } ent_t;

  typedef struct {
    logic [7:0]    d;
    logic [NS-1:0] g;
    int            cyc;
    int            idles;
  } rec_t;

  ent_t       sq [NS][$];
  logic [7:0] expq [NS][$];
  int         wait_c [NS];
  rec_t       out_log [$];
  logic [7:0] exp_seq [$];

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            idle_cnt = 0;
  int            hold_obs = 0;
  int            rdy1_cnt = 0;
  int            rdy_mode = 0;
  logic          prev_stall = 1'b0;
  logic [7:0]    prev_data = '0;
  logic [NS-1:0] fired;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic present(input int i);
    if (sq[i].size() > 0 && wait_c[i] == 0) begin
      src_tvalid[i]       = 1'b1;
      src_tdata[8*i +: 8] = sq[i][0].data;
      src_tlast[i]        = sq[i][0].last;
    end else begin
      src_tvalid[i]       = 1'b0;
      src_tdata[8*i +: 8] = '0;
      src_tlast[i]        = 1'b0;
      if (wait_c[i] > 0) wait_c[i]--;
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic last, input logic [7:0] gap);
    ent_t e;
    e.data = d;
    e.last = last;
    e.gap  = gap;
    sq[i].push_back(e);
    expq[i].push_back(d);
  endtask

  task automatic drv_clear();
    for (int i = 0; i < NS; i++) begin
      sq[i].delete();
      expq[i].delete();
      wait_c[i] = 0;
    end
    src_tvalid = '0;
    src_tdata  = '0;
    src_tlast  = '0;
  endtask

  // One clock: sample at negedge, then drive the next inputs just after posedge.
  task automatic cycle();
    rec_t r;
    @(negedge clk);
    if (rst_n && prev_stall) begin
      chk("stall_valid", 32'(m_tvalid), 32'd1);
      chk("stall_data", 32'(m_tdata), 32'(prev_data));
    end
    prev_stall = rst_n && m_tvalid && !m_tready;
    prev_data  = m_tdata;
    if (!busy) idle_cnt++;
    if (busy && !m_tvalid) hold_obs++;
    if (src_tready[1]) rdy1_cnt++;
    fired = src_tvalid & src_tready;
    if (rst_n && m_tvalid && m_tready) begin
      r.d     = m_tdata;
      r.g     = grant;
      r.cyc   = cyc;
      r.idles = idle_cnt;
      out_log.push_back(r);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NS; i++) begin
      if (fired[i] && sq[i].size() > 0) begin
        void'(sq[i].pop_front());
        wait_c[i] = (sq[i].size() > 0) ? int'(sq[i][0].gap) : 0;
      end
      present(i);
    end
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = 1'b0;
    endcase
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    rdy_mode = 0;
    m_tready = 1'b1;
    drv_clear();
    cycle();
    cycle();
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tdata", 32'(m_tdata), 32'd0);
    chk("rst_src_tready", 32'(src_tready), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    out_log.delete();
    idle_cnt = 0;
    hold_obs = 0;
    rdy1_cnt = 0;
  endtask

  task automatic run_until(input int n, input int budget);
    int k = 0;
    while (out_log.size() < n && k < budget) begin
      cycle();
      k++;
    end
    chk("out_count", 32'(out_log.size()), 32'(n));
  endtask

  task automatic chk_seq(input string tag, input int base);
    for (int j = 0; j < exp_seq.size(); j++) begin
      chk(tag, (base + j < out_log.size()) ? 32'(out_log[base + j].d) : 32'hFFFF_FFFF,
          32'(exp_seq[j]));
    end
  endtask

  function automatic int tag_to_src(input logic [7:0] t);
    case (t)
      8'h03:   return 0;
      8'h02:   return 1;
      8'h05:   return 2;
      default: return -1;
    endcase
  endfunction

  initial begin
    int base;
    int s;
    int left;
    rst_n      = 1'b0;
    m_tready   = 1'b0;
    src_tvalid = '0;
    src_tdata  = '0;
    src_tlast  = '0;

    // Single byte from src1
    do_reset();
    push(1, 8'hAB, 1'b1, 8'd0);
    run_until(2, 50);
    exp_seq = '{8'h02, 8'hAB};
    chk_seq("single_seq", 0);
    if (out_log.size() >= 2) begin
      chk("single_grant_tag", 32'(out_log[0].g), 32'b010);
      chk("single_grant_data", 32'(out_log[1].g), 32'b010);
    end
    cycle(); cycle(); cycle();
    chk("single_grant_after", 32'(grant), 32'd0);
    chk("single_busy_after", 32'(busy), 32'd0);
    chk("single_rdy1_cycles", 32'(rdy1_cnt), 32'd1);

    // Simultaneous requests
    do_reset();
    push(0, 8'h11, 1'b1, 8'd0);
    push(1, 8'h22, 1'b1, 8'd0);
    push(2, 8'h33, 1'b1, 8'd0);
    run_until(6, 100);
    exp_seq = '{8'h03, 8'h11, 8'h02, 8'h22, 8'h05, 8'h33};
    chk_seq("simul_seq", 0);

    // Burst limit
    do_reset();
    for (int k = 0; k < 20; k++) push(0, 8'(k), 1'b0, 8'd0);
    push(2, 8'hEE, 1'b1, 8'd0);
    exp_seq.delete();
    for (int k = 0; k < 16; k++) begin
      exp_seq.push_back(8'h03);
      exp_seq.push_back(8'(k));
    end
    exp_seq.push_back(8'h05);
    exp_seq.push_back(8'hEE);
    for (int k = 16; k < 20; k++) begin
      exp_seq.push_back(8'h03);
      exp_seq.push_back(8'(k));
    end
    run_until(42, 400);
    chk_seq("burst_seq", 0);

    // Hold timeout
    do_reset();
    push(0, 8'h01, 1'b0, 8'd0);
    push(0, 8'h77, 1'b1, 8'd10);
    push(1, 8'h55, 1'b1, 8'd0);
    run_until(6, 100);
    exp_seq = '{8'h03, 8'h01, 8'h02, 8'h55, 8'h03, 8'h77};
    chk_seq("hold_seq", 0);
    chk("hold_cycles", 32'(hold_obs), 32'd4);
    if (out_log.size() >= 6) begin
      chk("hold_gap", 32'(out_log[2].cyc - out_log[1].cyc), 32'd6);
      chk("hold_fresh_grant", 32'(out_log[4].idles > out_log[3].idles), 32'd1);
    end

    // Reset in the middle of src0's third byte
    do_reset();
    push(1, 8'h99, 1'b1, 8'd0);
    run_until(2, 50);
    cycle(); cycle();
    for (int k = 0; k < 6; k++) push(0, 8'(8'hA0 + k), 1'b0, 8'd0);
    run_until(7, 100);
    rdy_mode = 2;
    m_tready = 1'b0;
    rst_n    = 1'b0;
    cycle();
    chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst_src_tready", 32'(src_tready), 32'd0);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    drv_clear();
    push(0, 8'hC0, 1'b1, 8'd0);
    push(1, 8'hC1, 1'b1, 8'd0);
    push(2, 8'hC2, 1'b1, 8'd0);
    rdy_mode = 0;
    m_tready = 1'b1;
    rst_n    = 1'b1;
    base     = out_log.size();
    run_until(base + 2, 50);
    exp_seq = '{8'h03, 8'hC0};
    chk_seq("midrst_first", base);
    if (out_log.size() >= base + 1) chk("midrst_first_grant", 32'(out_log[base].g), 32'b001);

    // Random backpressure, 100 bytes spread over all sources
    do_reset();
    rdy_mode = 1;
    for (int k = 0; k < 100; k++) begin
      push($urandom_range(0, 2), 8'($urandom), 1'($urandom_range(0, 3) == 0),
           8'($urandom_range(0, 2)));
    end
    run_until(200, 8000);
    for (int j = 0; j + 1 < out_log.size(); j += 2) begin
      s = tag_to_src(out_log[j].d);
      chk("rand_tag_known", 32'(s >= 0), 32'd1);
      if (s >= 0) begin
        chk("rand_data", 32'(out_log[j + 1].d),
            (expq[s].size() > 0) ? 32'(expq[s].pop_front()) : 32'hFFFF_FFFF);
        chk("rand_tag_grant", 32'(out_log[j].g), 32'(1) << s);
        chk("rand_data_grant", 32'(out_log[j + 1].g), 32'(1) << s);
      end
    end
    left = 0;
    for (int i = 0; i < NS; i++) left += expq[i].size();
    chk("rand_all_delivered", 32'(left), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single host-bound UART byte stream among NUM_SRC byte-wide AXI4-Stream producers, e.g. TCP reassembly output, PHY TX frames and brain status.
- Uses round-robin arbitration with bounded bursts.
- Every forwarded data byte is preceded by its source's one-byte type tag, so the host parser sees {tag, data} pairs.
- Sits between the internal producers and the UART TX serializer.

Parameters:
- NUM_SRC, 3, number of requesting sources.
- SRC_TAGS, 24'h05_02_03, packed 8-bit tag per source; source i uses bits [8i+7:8i]. Default: src0=0x03 remaining layer, src1=0x02 eth frame out, src2=0x05 brain status.
- MAX_BURST, 16, maximum data bytes forwarded per grant (1..255).
- HOLD_CYCLES, 4, idle cycles a grant is held waiting for the granted source's next byte (1..255).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- src_tdata  in  8*NUM_SRC  source data; source i in bits [8i+7:8i].
- src_tvalid  in  NUM_SRC  source valid.
- src_tlast  in  NUM_SRC  source end-of-packet; releases the grant after that byte.
- src_tready  out  NUM_SRC  source ready.
- m_tdata  out  8  tag or data byte to UART TX.
- m_tvalid  out  1  output valid.
- m_tready  in  1  UART TX ready.
- grant  out  NUM_SRC  one-hot current grant; all zero when idle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, synchronous on clk:
  - State returns to IDLE; grant=0, beat_cnt=0, hold_cnt=0.
  - RR pointer set to NUM_SRC-1, so src0 has highest priority first.
  - Outputs while in IDLE: m_tvalid=0, m_tdata=0, src_tready=0, busy=0.
  - Reset mid-transfer abandons the transfer with no further output; a partially sent pair is not completed.
- States: IDLE, HDR, DATA, HOLD.
- IDLE:
  - Picks the first asserted src_tvalid searching from pointer+1 upward, wrapping modulo NUM_SRC.
  - Registers the one-hot grant, clears beat_cnt, and moves to HDR the next cycle (1-cycle arbitration latency).
  - Stays in IDLE if no source is valid.
- HDR:
  - m_tvalid=1, m_tdata=SRC_TAGS slice of the granted source, all src_tready=0.
  - On m_tvalid&m_tready, moves to DATA.
- DATA:
  - Combinational passthrough: m_tdata=src_tdata[g], m_tvalid=src_tvalid[g], src_tready[g]=m_tready; other src_tready=0.
  - On handshake, beat_cnt increments.
  - If src_tlast[g] or beat_cnt==MAX_BURST-1 (before increment): set pointer=g, clear grant, go to IDLE.
  - Otherwise clear hold_cnt and go to HOLD.
- HOLD:
  - m_tvalid=0, src_tready=0, grant held.
  - If src_tvalid[g], go to HDR.
  - Otherwise hold_cnt increments; at hold_cnt==HOLD_CYCLES-1, set pointer=g, clear grant, go to IDLE.
  - Holding applies even when no other source is requesting.
- A tag is emitted only when the granted source already has tvalid high. AXI-Stream persistence then guarantees its data byte follows, so a tag is never left dangling.
- Output stability: while m_tvalid=1 and m_tready=0, m_tdata stays stable in HDR (registered tag) and in DATA (AXI-Stream source rule).
- Back-to-back: IDLE costs exactly one dead cycle between grants.
- Throughput: with m_tready constantly high, each byte costs 2 output cycles, plus 1 HOLD cycle between consecutive bytes of the same grant.
- Fairness: after a grant ends, the released source has lowest priority in the next arbitration.
- src_tlast on a byte that is also the MAX_BURST-th byte gives a single release, no double handling.
- Counter widths: beat_cnt and hold_cnt are 8 bits; comparisons are unsigned.

Test Plan:
- Single byte: after reset, src1 presents 0xAB with tlast=1, m_tready=1 -> m stream 0x02, 0xAB; grant=3'b010 during transfer, then 0; src_tready[1] high for exactly one cycle.
- Simultaneous requests: src0/1/2 each present one byte with tlast (0x11/0x22/0x33) at the same cycle after reset -> output 03 11 02 22 05 33, in that order.
- Burst limit: MAX_BURST=16, src0 streams 20 bytes 0x00..0x13 without tlast while src2 holds 0xEE -> 16 pairs (03,00)..(03,0F), then (05,EE), then src0 resumes with (03,10).
- Backpressure: random m_tready duty ~50% over 100 bytes from all sources -> no byte lost or duplicated; m_tdata constant whenever m_tvalid&!m_tready; every data byte is preceded by its correct tag.
- Hold timeout: HOLD_CYCLES=4, src0 sends 0x01, then a 10-cycle gap, while src1 holds 0x55 -> after (03,01), 4 HOLD cycles, then (02,55), then src0's later byte gets a fresh grant.
- Reset mid-burst: assert rst_n=0 in DATA during src0's 3rd byte -> next cycle m_tvalid=0, src_tready=0, grant=0; after release with all three valid, src0 is granted first.
